sb_scheduler: RTL and testbench

SB_SCHEDULER -- requirements
Module: sb_scheduler

---
 rtl/sb_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_sb_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_scheduler.sv
// Component-sequence scheduler: arbitrates header, DC and AC requesters into one set_bit stream.
// Optional protocol checker enabled by defining SB_SCHED_ERR_CHECK_EN.
module sb_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hdr_en,
    input  logic        hdr_valid,
    input  logic        dc_valid,
    input  logic        ac_valid,
    input  logic        hdr_last,
    input  logic        dc_last,
    input  logic        ac_last,
    input  logic [63:0] hdr_val,
    input  logic [63:0] dc_val,
    input  logic [63:0] ac_val,
    input  logic [6:0]  hdr_size,
    input  logic [6:0]  dc_size,
    input  logic [6:0]  ac_size,
    output logic        hdr_ready,
    output logic        dc_ready,
    output logic        ac_ready,
    output logic        out_enable,
    output logic [63:0] out_val,
    output logic [63:0] out_size_of_bit,
    output logic        out_flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] dc_bit_count,
    output logic [31:0] ac_bit_count,
    output logic        err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DC,
        S_AC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_xfer;
    logic        w_last;
    logic [63:0] w_val;
    logic [6:0]  w_size;
    logic [6:0]  w_eff;
    logic [63:0] w_mask;
    logic        w_emit;
    logic        w_start_ok;

    logic        r_out_enable;
    logic [63:0] r_out_val;
    logic [6:0]  r_out_size;
    logic [31:0] r_dc_count;
    logic [31:0] r_ac_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Only the requester owning the current phase is muxed onto the beat path
    always_comb begin
        w_next = r_state;
        w_xfer = 1'b0;
        w_last = 1'b0;
        w_val  = '0;
        w_size = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = hdr_en ? S_HDR : S_DC;
                end
            end
            S_HDR: begin
                w_xfer = hdr_valid;
                w_last = hdr_last;
                w_val  = hdr_val;
                w_size = hdr_size;
                if (hdr_valid && hdr_last) begin
                    w_next = S_DC;
                end
            end
            S_DC: begin
                w_xfer = dc_valid;
                w_last = dc_last;
                w_val  = dc_val;
                w_size = dc_size;
                if (dc_valid && dc_last) begin
                    w_next = S_AC;
                end
            end
            S_AC: begin
                w_xfer = ac_valid;
                w_last = ac_last;
                w_val  = ac_val;
                w_size = ac_size;
                if (ac_valid && ac_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign hdr_ready  = (r_state == S_HDR);
    assign dc_ready   = (r_state == S_DC);
    assign ac_ready   = (r_state == S_AC);
    assign out_flush  = (r_state == S_FLUSH);
    assign done       = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign w_start_ok = (r_state == S_IDLE) && start;

    assign w_eff  = (w_size > 7'd64) ? 7'd64 : w_size;
    assign w_mask = (w_eff == 7'd64) ? {64{1'b1}}
                                     : ((64'd1 << w_eff) - 64'd1);
    assign w_emit = w_xfer && (w_eff != 7'd0);

    // w_last only steers the FSM; the beat itself is emitted like any other
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_enable <= 1'b0;
            r_out_val    <= '0;
            r_out_size   <= '0;
        end else begin
            r_out_enable <= w_emit;
            r_out_val    <= w_emit ? (w_val & w_mask) : '0;
            r_out_size   <= w_emit ? w_eff : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dc_count <= '0;
            r_ac_count <= '0;
        end else if (w_start_ok) begin
            r_dc_count <= '0;
            r_ac_count <= '0;
        end else if (w_xfer && (r_state == S_DC)) begin
            r_dc_count <= r_dc_count + {25'd0, w_eff};
        end else if (w_xfer && (r_state == S_AC)) begin
            r_ac_count <= r_ac_count + {25'd0, w_eff};
        end
    end

    assign out_enable      = r_out_enable;
    assign out_val         = r_out_val;
    assign out_size_of_bit = {57'd0, r_out_size};
    assign dc_bit_count    = r_dc_count;
    assign ac_bit_count    = r_ac_count;

`ifdef SB_SCHED_ERR_CHECK_EN
    logic       w_viol;
    logic       r_err;
    logic [7:0] r_err_count;

    // Several offenders in one cycle still count as a single error
    assign w_viol = (r_state != S_IDLE) &&
                    ((hdr_valid && !hdr_ready) ||
                     (dc_valid && !dc_ready) ||
                     (ac_valid && !ac_ready));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else if (w_viol) begin
            r_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign err       = r_err;
    assign err_count = r_err_count;
`else
    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sb_scheduler.sv
// Directed bench for sb_scheduler: vector table for a full sequence plus
// hand-written sequences for size corners, protocol errors and async reset.
module tb_sb_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        hdr_en;
    logic        hdr_valid, dc_valid, ac_valid;
    logic        hdr_last, dc_last, ac_last;
    logic [63:0] hdr_val, dc_val, ac_val;
    logic [6:0]  hdr_size, dc_size, ac_size;
    logic        hdr_ready, dc_ready, ac_ready;
    logic        out_enable;
    logic [63:0] out_val;
    logic [63:0] out_size_of_bit;
    logic        out_flush;
    logic        busy;
    logic        done;
    logic [31:0] dc_bit_count, ac_bit_count;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    sb_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .hdr_en          (hdr_en),
        .hdr_valid       (hdr_valid),
        .dc_valid        (dc_valid),
        .ac_valid        (ac_valid),
        .hdr_last        (hdr_last),
        .dc_last         (dc_last),
        .ac_last         (ac_last),
        .hdr_val         (hdr_val),
        .dc_val          (dc_val),
        .ac_val          (ac_val),
        .hdr_size        (hdr_size),
        .dc_size         (dc_size),
        .ac_size         (ac_size),
        .hdr_ready       (hdr_ready),
        .dc_ready        (dc_ready),
        .ac_ready        (ac_ready),
        .out_enable      (out_enable),
        .out_val         (out_val),
        .out_size_of_bit (out_size_of_bit),
        .out_flush       (out_flush),
        .busy            (busy),
        .done            (done),
        .dc_bit_count    (dc_bit_count),
        .ac_bit_count    (ac_bit_count),
        .err             (err),
        .err_count       (err_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        st;
        logic        he;
        logic [2:0]  vm;
        logic        lst;
        logic [63:0] v;
        logic [6:0]  sz;
        logic [2:0]  rdy;
        logic        en;
        logic [63:0] ov;
        logic [6:0]  os;
        logic        fl;
        logic        dn;
        logic        bz;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic he, input logic [2:0] vm,
                         input logic lst, input logic [63:0] v,
                         input logic [6:0] s);
        start = st;
        hdr_en = he;
        {hdr_valid, dc_valid, ac_valid} = vm;
        hdr_last = lst;
        dc_last  = lst;
        ac_last  = lst;
        hdr_val  = v;
        dc_val   = v;
        ac_val   = v;
        hdr_size = s;
        dc_size  = s;
        ac_size  = s;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"}, {61'd0, hdr_ready, dc_ready, ac_ready}, 64'd0);
        chk({tag, " out_enable"}, {63'd0, out_enable}, 64'd0);
        chk({tag, " out_val"}, out_val, 64'd0);
        chk({tag, " out_size"}, out_size_of_bit, 64'd0);
        chk({tag, " flush/busy/done"}, {61'd0, out_flush, busy, done}, 64'd0);
        chk({tag, " dc_count"}, {32'd0, dc_bit_count}, 64'd0);
        chk({tag, " ac_count"}, {32'd0, ac_bit_count}, 64'd0);
        chk({tag, " err"}, {55'd0, err, err_count}, 64'd0);
    endtask

    logic [63:0] ones;
    logic        exp_err;
    logic [7:0]  exp_errc;

    initial begin
        ones = '1;
`ifdef SB_SCHED_ERR_CHECK_EN
        exp_err  = 1'b1;
        exp_errc = 8'd3;
`else
        exp_err  = 1'b0;
        exp_errc = 8'd0;
`endif
        // header 2x32, DC 3x5, AC 1x10; outputs lag the transfer by a cycle
        tbl[0] = '{1'b1, 1'b1, 3'b000, 1'b0, 64'h0, 7'd0,
                   3'b000, 1'b0, 64'h0, 7'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 3'b100, 1'b0, 64'hDEADBEEF, 7'd32,
                   3'b100, 1'b0, 64'h0, 7'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 3'b100, 1'b1, 64'h12345678, 7'd32,
                   3'b100, 1'b1, 64'hDEADBEEF, 7'd32, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 3'b010, 1'b0, 64'h15, 7'd5,
                   3'b010, 1'b1, 64'h12345678, 7'd32, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFEA, 7'd5,
                   3'b010, 1'b1, 64'h15, 7'd5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 3'b010, 1'b1, 64'h1F, 7'd5,
                   3'b010, 1'b1, 64'h0A, 7'd5, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 3'b001, 1'b1, 64'hFFFF_FFFF_FFFF_F2A5, 7'd10,
                   3'b001, 1'b1, 64'h1F, 7'd5, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0,
                   3'b000, 1'b1, 64'h2A5, 7'd10, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0,
                   3'b000, 1'b0, 64'h0, 7'd0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0,
                   3'b000, 1'b0, 64'h0, 7'd0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        #12;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].st, tbl[i].he, tbl[i].vm, tbl[i].lst,
                  tbl[i].v, tbl[i].sz);
            #1;
            chk($sformatf("row%0d ready", i),
                {61'd0, hdr_ready, dc_ready, ac_ready}, {61'd0, tbl[i].rdy});
            chk($sformatf("row%0d out_enable", i),
                {63'd0, out_enable}, {63'd0, tbl[i].en});
            chk($sformatf("row%0d out_val", i), out_val, tbl[i].ov);
            chk($sformatf("row%0d out_size", i),
                out_size_of_bit, {57'd0, tbl[i].os});
            chk($sformatf("row%0d flush/done/busy", i),
                {61'd0, out_flush, done, busy},
                {61'd0, tbl[i].fl, tbl[i].dn, tbl[i].bz});
            step();
        end
        chk("seq1 dc_count", {32'd0, dc_bit_count}, 64'd15);
        chk("seq1 ac_count", {32'd0, ac_bit_count}, 64'd10);
        chk("seq1 err", {55'd0, err, err_count}, 64'd0);

        // no header, zero-size DC beat, oversized AC beat
        drive(1'b1, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        #1;
        chk("s2 idle busy", {63'd0, busy}, 64'd0);
        step();
        drive(1'b0, 1'b0, 3'b010, 1'b1, 64'hFF, 7'd0);
        #1;
        chk("s2 dc ready", {61'd0, hdr_ready, dc_ready, ac_ready}, 64'b010);
        chk("s2 busy dc", {63'd0, busy}, 64'd1);
        step();
        drive(1'b0, 1'b0, 3'b001, 1'b1, ones, 7'd70);
        #1;
        chk("s3 size0 no enable", {63'd0, out_enable}, 64'd0);
        chk("s3 ac ready", {61'd0, hdr_ready, dc_ready, ac_ready}, 64'b001);
        step();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        #1;
        chk("s3 clamp enable", {63'd0, out_enable}, 64'd1);
        chk("s3 clamp val", out_val, ones);
        chk("s3 clamp size", out_size_of_bit, 64'd64);
        chk("s3 flush", {63'd0, out_flush}, 64'd1);
        step();
        chk("s2 done busy", {62'd0, done, busy}, 64'b11);
        chk("s2 hdr ready", {63'd0, hdr_ready}, 64'd0);
        step();
        chk("s2 after done", {62'd0, done, busy}, 64'b00);
        chk("s3 dc_count", {32'd0, dc_bit_count}, 64'd0);
        chk("s3 ac_count", {32'd0, ac_bit_count}, 64'd64);

        // out-of-phase AC valid during DC, plus a stray start mid-phase
        drive(1'b1, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        step();
        chk("s4 counts cleared", {dc_bit_count, ac_bit_count}, 64'd0);
        drive(1'b0, 1'b0, 3'b001, 1'b0, 64'h0, 7'd0);
        #1;
        chk("s4 ac not ready", {62'd0, dc_ready, ac_ready}, 64'b10);
        step();
        drive(1'b1, 1'b0, 3'b011, 1'b0, 64'h3, 7'd3);
        step();
        drive(1'b0, 1'b0, 3'b011, 1'b1, 64'h5, 7'd3);
        #1;
        chk("s6 start ignored count", {32'd0, dc_bit_count}, 64'd3);
        chk("s6 still dc", {62'd0, dc_ready, ac_ready}, 64'b10);
        step();
        drive(1'b0, 1'b0, 3'b001, 1'b1, 64'h1, 7'd4);
        #1;
        chk("s6 dc_count", {32'd0, dc_bit_count}, 64'd6);
        step();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        step();
        step();
        step();
        chk("s4 err", {63'd0, err}, {63'd0, exp_err});
        chk("s4 err_count", {56'd0, err_count}, {56'd0, exp_errc});
        chk("s4 ac_count", {32'd0, ac_bit_count}, 64'd4);
        chk("s4 idle", {63'd0, busy}, 64'd0);

        // asynchronous reset in the middle of the AC phase
        drive(1'b1, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        step();
        drive(1'b0, 1'b0, 3'b010, 1'b1, 64'hAB, 7'd8);
        step();
        drive(1'b0, 1'b0, 3'b001, 1'b0, 64'h2A, 7'd6);
        step();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        #1;
        chk("s5 pre-reset enable", {63'd0, out_enable}, 64'd1);
        chk("s5 pre-reset ac_count", {32'd0, ac_bit_count}, 64'd6);
        reset = 1'b1;
        #1;
        chk_all_zero("s5 async");
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("s5 quiet%0d", i),
                {61'd0, out_flush, done, busy}, 64'd0);
            step();
        end
        drive(1'b1, 1'b1, 3'b000, 1'b0, 64'h0, 7'd0);
        step();
        drive(1'b0, 1'b0, 3'b100, 1'b1, 64'h9, 7'd4);
        #1;
        chk("s5 hdr ready", {61'd0, hdr_ready, dc_ready, ac_ready}, 64'b100);
        step();
        drive(1'b0, 1'b0, 3'b010, 1'b1, 64'h2, 7'd2);
        #1;
        chk("s5 hdr out", {out_val[62:0], out_enable}, {63'h9, 1'b1});
        step();
        drive(1'b0, 1'b0, 3'b001, 1'b1, 64'h5, 7'd3);
        step();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 7'd0);
        #1;
        chk("s5 flush", {63'd0, out_flush}, 64'd1);
        step();
        chk("s5 done", {63'd0, done}, 64'd1);
        step();
        chk("s5 counts", {dc_bit_count, ac_bit_count}, {32'd2, 32'd3});
        chk("s5 idle err", {54'd0, busy, err, err_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
